// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch unit.
// State encoding plus PC step sizes for word and byte addressing.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam int unsigned STEP_WORD = 1;
    localparam int unsigned STEP_BYTE = 4;

    function automatic int unsigned pc_step(input bit byte_addr);
        return byte_addr ? STEP_BYTE : STEP_WORD;
    endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
// All arithmetic wraps modulo 2^ADDR_W.
module mips_next_pc
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter bit BYTE_ADDR = 1'b0
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_branch,
    input  logic              i_bneq,
    input  logic              i_zero,
    input  logic              i_jump,
    input  logic              i_jr,
    input  logic [31:0]       i_imm,
    input  logic [ADDR_W-1:0] i_jr_target,
    input  logic [25:0]       i_j_index,
    output logic [ADDR_W-1:0] o_seq,
    output logic [ADDR_W-1:0] o_next_pc
);

    localparam logic [ADDR_W-1:0] STEP =
        ADDR_W'(pc_step(BYTE_ADDR));
    localparam logic [ADDR_W-1:0] HI_MASK =
        ~ADDR_W'(28'hFFF_FFFF);

    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_br;
    logic [ADDR_W-1:0] w_jmp;
    logic [ADDR_W-1:0] w_jr_tgt;
    logic              w_taken;
    logic              w_sel_jr;
    logic              w_sel_j;
    logic              w_sel_br;

    assign o_seq    = i_pc + STEP;
    assign w_off    = BYTE_ADDR ? (ADDR_W'($signed(i_imm)) << 2)
                                : ADDR_W'($signed(i_imm));
    assign w_br     = o_seq + w_off;
    assign w_jmp    = BYTE_ADDR
                    ? ((o_seq & HI_MASK) | (ADDR_W'(i_j_index) << 2))
                    : ADDR_W'(i_j_index);
    assign w_jr_tgt = BYTE_ADDR ? (i_jr_target & ~ADDR_W'(3))
                                : i_jr_target;
    assign w_taken  = i_branch & (i_zero ^ i_bneq);

    // Qualified selects are one-hot so the priority order is explicit.
    assign w_sel_jr = i_jr;
    assign w_sel_j  = i_jump & ~i_jr;
    assign w_sel_br = w_taken & ~i_jump & ~i_jr;

    always_comb begin
        o_next_pc = o_seq;
        unique case (1'b1)
            w_sel_jr: o_next_pc = w_jr_tgt;
            w_sel_j:  o_next_pc = w_jmp;
            w_sel_br: o_next_pc = w_br;
            default:  o_next_pc = o_seq;
        endcase
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: requests one word, holds it for the core,
// then advances the PC by the selected next-PC rule on consume.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter bit              BYTE_ADDR = 1'b0,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              CNT_W     = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              branch,
    input  logic              bneq,
    input  logic              zero,
    input  logic              jump,
    input  logic              jr,
    input  logic [31:0]       imm,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic [25:0]       j_index,
    output logic [ADDR_W-1:0] link_addr,
    output logic [CNT_W-1:0]  retired
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [31:0]       r_inst;
    logic [CNT_W-1:0]  r_retired;
    logic              r_req;
    logic              r_valid;
    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_next_pc;

    mips_next_pc #(
        .ADDR_W    (ADDR_W),
        .BYTE_ADDR (BYTE_ADDR)
    ) u_next_pc (
        .i_pc        (r_inst_pc),
        .i_branch    (branch),
        .i_bneq      (bneq),
        .i_zero      (zero),
        .i_jump      (jump),
        .i_jr        (jr),
        .i_imm       (imm),
        .i_jr_target (jr_target),
        .i_j_index   (j_index),
        .o_seq       (w_seq),
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_RST;
            r_pc      <= RESET_VEC;
            r_inst    <= '0;
            r_inst_pc <= RESET_VEC;
            r_retired <= '0;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                S_RST: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_inst    <= imem_rdata;
                        r_inst_pc <= r_pc;
                        r_req     <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + CNT_W'(1);
                        r_valid   <= 1'b0;
                        r_req     <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_RST;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign inst_valid = r_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign link_addr  = w_seq;
    assign retired    = r_retired;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: three configurations driven in lockstep,
// directed scenarios followed by random traffic against a PC model.
module tb_mips_fetch_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, ack, ready;
    logic        branch, bneq, zero, jump, jr;
    logic [31:0] rdata, imm, jrt;
    logic [25:0] jidx;

    logic        req0, req1, req2, val0, val1, val2;
    logic [31:0] addr0, addr1, inst0, inst1, inst2;
    logic [31:0] ipc0, ipc1, link0, link1, ret0, ret1;
    logic [7:0]  addr2, ipc2, link2;
    logic [3:0]  ret2;

    mips_fetch_unit u0 (
        .clock(clock), .reset_n(reset_n),
        .imem_req(req0), .imem_addr(addr0),
        .imem_ack(ack), .imem_rdata(rdata),
        .inst_valid(val0), .inst(inst0), .inst_pc(ipc0),
        .inst_ready(ready),
        .branch(branch), .bneq(bneq), .zero(zero),
        .jump(jump), .jr(jr),
        .imm(imm), .jr_target(jrt), .j_index(jidx),
        .link_addr(link0), .retired(ret0)
    );

    mips_fetch_unit #(
        .BYTE_ADDR(1'b1), .RESET_VEC(32'h1000_0004)
    ) u1 (
        .clock(clock), .reset_n(reset_n),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack), .imem_rdata(rdata),
        .inst_valid(val1), .inst(inst1), .inst_pc(ipc1),
        .inst_ready(ready),
        .branch(branch), .bneq(bneq), .zero(zero),
        .jump(jump), .jr(jr),
        .imm(imm), .jr_target(jrt), .j_index(jidx),
        .link_addr(link1), .retired(ret1)
    );

    mips_fetch_unit #(
        .ADDR_W(8), .RESET_VEC(8'hFF), .CNT_W(4)
    ) u2 (
        .clock(clock), .reset_n(reset_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack), .imem_rdata(rdata),
        .inst_valid(val2), .inst(inst2), .inst_pc(ipc2),
        .inst_ready(ready),
        .branch(branch), .bneq(bneq), .zero(zero),
        .jump(jump), .jr(jr),
        .imm(imm), .jr_target(jrt[7:0]), .j_index(jidx),
        .link_addr(link2), .retired(ret2)
    );

    logic [63:0] g_req [3], g_val [3], g_addr [3], g_inst [3];
    logic [63:0] g_ipc [3], g_link [3], g_ret [3];
    assign g_req[0]  = 64'(req0);
    assign g_req[1]  = 64'(req1);
    assign g_req[2]  = 64'(req2);
    assign g_val[0]  = 64'(val0);
    assign g_val[1]  = 64'(val1);
    assign g_val[2]  = 64'(val2);
    assign g_addr[0] = 64'(addr0);
    assign g_addr[1] = 64'(addr1);
    assign g_addr[2] = 64'(addr2);
    assign g_inst[0] = 64'(inst0);
    assign g_inst[1] = 64'(inst1);
    assign g_inst[2] = 64'(inst2);
    assign g_ipc[0]  = 64'(ipc0);
    assign g_ipc[1]  = 64'(ipc1);
    assign g_ipc[2]  = 64'(ipc2);
    assign g_link[0] = 64'(link0);
    assign g_link[1] = 64'(link1);
    assign g_link[2] = 64'(link2);
    assign g_ret[0]  = 64'(ret0);
    assign g_ret[1]  = 64'(ret1);
    assign g_ret[2]  = 64'(ret2);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-configuration parameters of the three instances.
    int              AW [3] = '{32, 32, 8};
    int              BY [3] = '{0, 1, 0};
    int              CW [3] = '{32, 32, 4};
    longint unsigned RV [3] = '{64'h0, 64'h1000_0004, 64'hFF};

    // Model: 0 = in reset, 1 = awaiting memory, 2 = holding instruction.
    int              m_ph;
    logic [31:0]     m_inst;
    longint unsigned m_pc [3], m_ipc [3], m_ret [3];

    function automatic longint unsigned msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint unsigned stp(input int k);
        return (BY[k] != 0) ? 64'd4 : 64'd1;
    endfunction

    function automatic longint unsigned ref_next(input int k,
                                                 input longint unsigned pc);
        longint unsigned m, seq, off;
        m   = msk(AW[k]);
        seq = (pc + stp(k)) & m;
        if (jr)
            return (BY[k] != 0) ? (64'(jrt) & m & ~64'd3) : (64'(jrt) & m);
        if (jump) begin
            if (BY[k] != 0)
                return ((seq & ~64'h0FFF_FFFF) | (64'(jidx) << 2)) & m;
            return 64'(jidx) & m;
        end
        if (branch && (zero != bneq)) begin
            off = {{32{imm[31]}}, imm};
            if (BY[k] != 0) off = off << 2;
            return (seq + off) & m;
        end
        return seq;
    endfunction

    task automatic model_update();
        if (!reset_n) begin
            m_ph = 0;
            m_inst = '0;
            for (int k = 0; k < 3; k++) begin
                m_pc[k] = RV[k];
                m_ipc[k] = RV[k];
                m_ret[k] = 0;
            end
        end else if (m_ph == 0) begin
            m_ph = 1;
        end else if (m_ph == 1) begin
            if (ack) begin
                m_inst = rdata;
                for (int k = 0; k < 3; k++) m_ipc[k] = m_pc[k];
                m_ph = 2;
            end
        end else if (ready) begin
            for (int k = 0; k < 3; k++) begin
                m_pc[k]  = ref_next(k, m_ipc[k]);
                m_ret[k] = (m_ret[k] + 1) & msk(CW[k]);
            end
            m_ph = 1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("req%0d", k), g_req[k], 64'(m_ph == 1));
            check($sformatf("valid%0d", k), g_val[k], 64'(m_ph == 2));
            check($sformatf("ret%0d", k), g_ret[k], m_ret[k]);
            check($sformatf("inst%0d", k), g_inst[k], 64'(m_inst));
            check($sformatf("ipc%0d", k), g_ipc[k], m_ipc[k]);
            check($sformatf("link%0d", k), g_link[k],
                  (m_ipc[k] + stp(k)) & msk(AW[k]));
            if (m_ph == 1)
                check($sformatf("addr%0d", k), g_addr[k], m_pc[k]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
        check_all();
    endtask

    task automatic clear_dec();
        branch = 0; bneq = 0; zero = 0; jump = 0; jr = 0;
        imm = '0; jrt = '0; jidx = '0;
    endtask

    initial begin
        reset_n = 0; ack = 0; ready = 0;
        rdata = $urandom;
        clear_dec();
        m_ph = 0;
        tick();
        tick();
        check("rst_req", g_req[0], 0);
        check("rst_valid", g_val[0], 0);
        check("rst_ret", g_ret[0], 0);
        check("rst_inst", g_inst[0], 0);
        check("rst_ipc1", g_ipc[1], 64'h1000_0004);

        reset_n = 1;
        tick();
        check("first_addr", g_addr[0], 0);

        // Jump at byte-addressed inst_pc 0x1000_0004.
        ack = 1; rdata = $urandom;
        tick();
        ack = 0; ready = 1; jump = 1; jidx = 26'h40;
        tick();
        clear_dec();
        check("j_byte", g_addr[1], 64'h1000_0100);
        check("j_word", g_addr[0], 64'h40);

        // jr outranks jump; low bits dropped when byte-addressed.
        ack = 1;
        tick();
        ack = 0; jr = 1; jump = 1; jrt = 32'h203;
        tick();
        clear_dec();
        check("jr_byte", g_addr[1], 64'h200);
        check("jr_word", g_addr[0], 64'h203);

        // Reset while fetching, ack pulsed in reset state.
        reset_n = 0;
        tick();
        check("rst2_req", g_req[0], 0);
        check("rst2_ret", g_ret[0], 0);
        reset_n = 1; ack = 1;
        tick();
        check("rst2_valid", g_val[0], 0);
        check("rst2_addr0", g_addr[0], 0);
        check("rst2_addr1", g_addr[1], 64'h1000_0004);

        // Back-to-back sequential fetch.
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", g_addr[0], 64'(i));
            check("wrap", g_addr[2], 64'((255 + i) & 255));
            rdata = $urandom;
            tick();
            check("seq_valid", g_val[0], 1);
            tick();
        end
        check("seq_ret", g_ret[0], 4);

        // beq taken, then bne not taken, both at inst_pc 5.
        tick();
        tick();
        tick();
        check("br_ipc", g_ipc[0], 5);
        branch = 1; zero = 1; bneq = 0; imm = 32'hFFFF_FFFD;
        tick();
        clear_dec();
        check("beq", g_addr[0], 3);
        for (int i = 0; i < 5; i++) tick();
        check("br_ipc2", g_ipc[0], 5);
        branch = 1; zero = 1; bneq = 1; imm = 32'hFFFF_FFFD;
        tick();
        clear_dec();
        check("bne", g_addr[0], 6);

        // Backpressure on both handshakes.
        ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_addr", g_addr[0], 6);
        end
        rdata = 32'hCAFE_F00D; ack = 1;
        tick();
        ack = 0; ready = 0;
        for (int i = 0; i < 2; i++) begin
            rdata = $urandom;
            tick();
            check("bp_inst", g_inst[0], 64'hCAFE_F00D);
            check("bp_ipc", g_ipc[0], 6);
            check("bp_ret", g_ret[0], 9);
        end
        ready = 1;
        tick();
        check("bp_ret2", g_ret[0], 10);
        check("bp_next", g_addr[0], 7);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            ack     = 1'($urandom_range(0, 1));
            ready   = ($urandom_range(0, 9) < 6);
            branch  = 1'($urandom_range(0, 1));
            bneq    = 1'($urandom_range(0, 1));
            zero    = 1'($urandom_range(0, 1));
            jump    = ($urandom_range(0, 7) == 0);
            jr      = ($urandom_range(0, 9) == 0);
            imm     = $urandom_range(0, 1) != 0 ? $urandom
                    : 32'($urandom_range(0, 31)) - 32'd16;
            jrt     = $urandom;
            jidx    = 26'($urandom);
            rdata   = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
